// File: rtl/vreg_wb_arbiter_pkg.sv
// Shared vector-register types and sizing for the writeback arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vreg_wb_arbiter_pkg;

  localparam int DATA_W = 256;
  localparam int NREG   = 4;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] vreg_idx_t;

  // Requester identity doubles as the bit position in request/grant vectors.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_t;

endpackage

// File: rtl/vreg_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a 1-bit last-grant pointer.
// Latency: grant is combinational from requests; pointer updates at the grant posedge.
// Backpressure: an ungranted requester simply sees its grant low and must hold its request.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_vld,
  output logic [1:0] gnt
);
  import vreg_wb_arbiter_pkg::*;

  req_id_t last_q;
  req_id_t last_d;

  // Grant the sole requester, or on contention the one not granted last.
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (req_vld[REQ_ALU] && req_vld[REQ_LSU]) begin
      if (last_q == REQ_LSU) begin
        gnt[REQ_ALU] = 1'b1;
      end else begin
        gnt[REQ_LSU] = 1'b1;
      end
    end else begin
      gnt = req_vld;
    end
    if (gnt[REQ_LSU]) begin
      last_d = REQ_LSU;
    end else if (gnt[REQ_ALU]) begin
      last_d = REQ_ALU;
    end
  end

  // Pointer resets to LSU so the ALU wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vreg_wb_arbiter.sv
// Vector register writeback arbiter with busy scoreboard and issue interlock.
// Latency: one cycle from transfer posedge to registered WE/A3/WB; BUSY clears when WE pulse ends.
// Backpressure: READY is a combinational round-robin grant; ISSUE_STALL refuses issues touching busy registers.
module vreg_wb_arbiter #(
  parameter int DATA_W = vreg_wb_arbiter_pkg::DATA_W,
  parameter int NREG   = vreg_wb_arbiter_pkg::NREG
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ISSUE_VALID,
  input  logic [$clog2(NREG)-1:0]  ISSUE_RS1,
  input  logic [$clog2(NREG)-1:0]  ISSUE_RS2,
  input  logic [$clog2(NREG)-1:0]  ISSUE_RD,
  output logic                     ISSUE_STALL,
  input  logic                     ALU_VALID,
  input  logic [$clog2(NREG)-1:0]  ALU_ADDR,
  input  logic [DATA_W-1:0]        ALU_DATA,
  output logic                     ALU_READY,
  input  logic                     LSU_VALID,
  input  logic [$clog2(NREG)-1:0]  LSU_ADDR,
  input  logic [DATA_W-1:0]        LSU_DATA,
  output logic                     LSU_READY,
  output logic                     WE,
  output logic [$clog2(NREG)-1:0]  A3,
  output logic [DATA_W-1:0]        WB,
  output logic [NREG-1:0]          BUSY,
  output logic                     ERR
);
  import vreg_wb_arbiter_pkg::*;

  localparam int AW = $clog2(NREG);

  logic [1:0]        req_vld;
  logic [1:0]        gnt;

  logic              we_q,   we_d;
  logic [AW-1:0]     a3_q,   a3_d;
  logic [DATA_W-1:0] wb_q,   wb_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q,  err_d;

  logic              xfer;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              issue_ok;
  logic [NREG-1:0]   busy_set;
  logic [NREG-1:0]   busy_clr;

  assign req_vld[REQ_ALU] = ALU_VALID;
  assign req_vld[REQ_LSU] = LSU_VALID;

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req_vld (req_vld),
    .gnt     (gnt)
  );

  assign ALU_READY = gnt[REQ_ALU];
  assign LSU_READY = gnt[REQ_LSU];

  // Interlock uses registered BUSY only, so a register being written this cycle still stalls.
  assign ISSUE_STALL = ISSUE_VALID &
                       (busy_q[ISSUE_RS1] | busy_q[ISSUE_RS2] | busy_q[ISSUE_RD]);

  // Select the granted writeback, update scoreboard (set wins over clear), and flag orphan writes.
  always_comb begin
    xfer     = |gnt;
    sel_addr = gnt[REQ_LSU] ? LSU_ADDR : ALU_ADDR;
    sel_data = gnt[REQ_LSU] ? LSU_DATA : ALU_DATA;

    we_d = xfer;
    a3_d = xfer ? sel_addr : a3_q;
    wb_d = xfer ? sel_data : wb_q;

    issue_ok = ISSUE_VALID & ~ISSUE_STALL;
    busy_set = '0;
    busy_clr = '0;
    if (issue_ok) begin
      busy_set[ISSUE_RD] = 1'b1;
    end
    if (we_q) begin
      busy_clr[a3_q] = 1'b1;
    end
    busy_d = (busy_q & ~busy_clr) | busy_set;

    err_d = err_q | (xfer & ~busy_q[sel_addr]);
  end

  // Output register and scoreboard; reset drops any in-flight write and all pending state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q   <= 1'b0;
      a3_q   <= '0;
      wb_q   <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      a3_q   <= a3_d;
      wb_q   <= wb_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign WE   = we_q;
  assign A3   = a3_q;
  assign WB   = wb_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
// Directed self-checking bench for the vector writeback arbiter.
// Latency: checks are taken 2-3 time units after each rising edge.
// Backpressure: exercises grant alternation and issue stalls on busy registers.
module tb_vreg_wb_arbiter;

  localparam int DW = 256;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ISSUE_VALID;
  logic [1:0]    ISSUE_RS1, ISSUE_RS2, ISSUE_RD;
  logic          ISSUE_STALL;
  logic          ALU_VALID, LSU_VALID;
  logic [1:0]    ALU_ADDR, LSU_ADDR;
  logic [DW-1:0] ALU_DATA, LSU_DATA;
  logic          ALU_READY, LSU_READY;
  logic          WE;
  logic [1:0]    A3;
  logic [DW-1:0] WB;
  logic [3:0]    BUSY;
  logic          ERR;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] d_a5, d_11, d_22, d_ee, d_3c;

  vreg_wb_arbiter dut (
    .CLK         (CLK),
    .RST         (RST),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_RS1   (ISSUE_RS1),
    .ISSUE_RS2   (ISSUE_RS2),
    .ISSUE_RD    (ISSUE_RD),
    .ISSUE_STALL (ISSUE_STALL),
    .ALU_VALID   (ALU_VALID),
    .ALU_ADDR    (ALU_ADDR),
    .ALU_DATA    (ALU_DATA),
    .ALU_READY   (ALU_READY),
    .LSU_VALID   (LSU_VALID),
    .LSU_ADDR    (LSU_ADDR),
    .LSU_DATA    (LSU_DATA),
    .LSU_READY   (LSU_READY),
    .WE          (WE),
    .A3          (A3),
    .WB          (WB),
    .BUSY        (BUSY),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    d_a5 = {32{8'hA5}};
    d_11 = {32{8'h11}};
    d_22 = {32{8'h22}};
    d_ee = {32{8'hEE}};
    d_3c = {32{8'h3C}};

    RST = 1'b1;
    ISSUE_VALID = 1'b0; ISSUE_RS1 = 2'd0; ISSUE_RS2 = 2'd0; ISSUE_RD = 2'd0;
    ALU_VALID = 1'b0; ALU_ADDR = 2'd0; ALU_DATA = '0;
    LSU_VALID = 1'b0; LSU_ADDR = 2'd0; LSU_DATA = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_we",   WE,   0);
    chk("rst_a3",   A3,   0);
    chk("rst_wb",   WB,   0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err",  ERR,  0);
    RST = 1'b0;

    // Issue RD=2 RS1=0 RS2=1 from idle
    ISSUE_VALID = 1'b1; ISSUE_RS1 = 2'd0; ISSUE_RS2 = 2'd1; ISSUE_RD = 2'd2;
    #1 chk("issue0_stall", ISSUE_STALL, 0);
    tick();
    ISSUE_VALID = 1'b0;
    #1 chk("issue0_busy", BUSY, 4'b0100);

    // Stall on busy source, then ALU writeback releases it
    ISSUE_VALID = 1'b1; ISSUE_RS1 = 2'd2; ISSUE_RS2 = 2'd0; ISSUE_RD = 2'd3;
    #1 chk("raw_stall", ISSUE_STALL, 1);
    ALU_VALID = 1'b1; ALU_ADDR = 2'd2; ALU_DATA = d_a5;
    #1 chk("alu_only_ardy", ALU_READY, 1);
    chk("alu_only_lrdy", LSU_READY, 0);
    tick();
    ALU_VALID = 1'b0; ALU_DATA = '0;
    #1 chk("wb2_we", WE, 1);
    chk("wb2_a3", A3, 2);
    chk("wb2_wb", WB, d_a5);
    chk("wb2_busy_held", BUSY, 4'b0100);
    chk("wb2_no_bypass", ISSUE_STALL, 1);
    tick();
    #1 chk("wb2_we_off", WE, 0);
    chk("wb2_busy_clr", BUSY, 4'b0000);
    chk("wb2_stall_drop", ISSUE_STALL, 0);
    ISSUE_VALID = 1'b0;
    chk("wb2_a3_hold", A3, 2);
    chk("wb2_wb_hold", WB, d_a5);
    chk("wb2_err", ERR, 0);

    // Fresh reset so the pointer starts at LSU again
    RST = 1'b1;
    tick();
    RST = 1'b0;

    // Build BUSY=0011, then contend for two cycles
    ISSUE_VALID = 1'b1; ISSUE_RS1 = 2'd0; ISSUE_RS2 = 2'd0; ISSUE_RD = 2'd0;
    tick();
    ISSUE_RS1 = 2'd1; ISSUE_RS2 = 2'd1; ISSUE_RD = 2'd1;
    tick();
    ISSUE_VALID = 1'b0;
    #1 chk("rr_busy_pre", BUSY, 4'b0011);
    ALU_VALID = 1'b1; ALU_ADDR = 2'd0; ALU_DATA = d_11;
    LSU_VALID = 1'b1; LSU_ADDR = 2'd1; LSU_DATA = d_ee;
    #1 chk("rr1_ardy", ALU_READY, 1);
    chk("rr1_lrdy", LSU_READY, 0);
    tick();
    LSU_DATA = d_22;
    #1 chk("rr1_we", WE, 1);
    chk("rr1_a3", A3, 0);
    chk("rr1_wb", WB, d_11);
    chk("rr2_ardy", ALU_READY, 0);
    chk("rr2_lrdy", LSU_READY, 1);
    tick();
    ALU_VALID = 1'b0; LSU_VALID = 1'b0;
    #1 chk("rr2_we", WE, 1);
    chk("rr2_a3", A3, 1);
    chk("rr2_wb", WB, d_22);
    chk("rr2_busy", BUSY, 4'b0010);
    tick();
    #1 chk("rr_we_off", WE, 0);
    chk("rr_busy_done", BUSY, 4'b0000);
    chk("rr_err", ERR, 0);

    // Orphan LSU write to a clear register raises sticky ERR
    LSU_VALID = 1'b1; LSU_ADDR = 2'd3; LSU_DATA = d_3c;
    #1 chk("orph_lrdy", LSU_READY, 1);
    tick();
    LSU_VALID = 1'b0;
    #1 chk("orph_we", WE, 1);
    chk("orph_a3", A3, 3);
    chk("orph_wb", WB, d_3c);
    chk("orph_err", ERR, 1);
    repeat (3) tick();
    #1 chk("orph_err_sticky", ERR, 1);
    chk("orph_we_off", WE, 0);
    chk("orph_busy", BUSY, 4'b0000);

    // Reset during a WE cycle with every register busy
    ISSUE_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ISSUE_RS1 = 2'(i); ISSUE_RS2 = 2'(i); ISSUE_RD = 2'(i);
      tick();
    end
    ISSUE_VALID = 1'b0;
    #1 chk("full_busy", BUSY, 4'b1111);
    ALU_VALID = 1'b1; ALU_ADDR = 2'd0; ALU_DATA = d_11;
    tick();
    ALU_VALID = 1'b0;
    #1 chk("midrst_we_pre", WE, 1);
    RST = 1'b1;
    #1 chk("midrst_we", WE, 0);
    chk("midrst_busy", BUSY, 4'b0000);
    chk("midrst_err", ERR, 0);
    chk("midrst_a3", A3, 0);
    chk("midrst_wb", WB, 0);
    tick();
    RST = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_we", WE, 0);
    end
    chk("post_rst_busy", BUSY, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
